// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  // Access size; unknown store sizes and reserved load codes fall back to word.
  function automatic size_e decode_size(input logic is_store, input logic [2:0] f3);
    size_e s;
    if (is_store) begin
      case (f3)
        F3_B:    s = SIZE_B;
        F3_H:    s = SIZE_H;
        default: s = SIZE_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: s = SIZE_B;
        F3_H, F3_HU: s = SIZE_H;
        F3_W:        s = SIZE_W;
        default:     s = SIZE_W;
      endcase
    end
    return s;
  endfunction

  // Natural-alignment rule: halves need even, words need 4-byte aligned.
  function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
    logic m;
    case (s)
      SIZE_H:  m = off[0];
      SIZE_W:  m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage and memory-bus signals of the load/store unit.
interface load_store_unit_if;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] read_data;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // LSU side
  modport slave (
    input  start, opcode, funct3, addr, store_data, mem_ack, mem_rdata,
    output stall, done, read_data, misaligned, bus_error,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Pipeline / memory-model side
  modport master (
    output start, opcode, funct3, addr, store_data, mem_ack, mem_rdata,
    input  stall, done, read_data, misaligned, bus_error,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication and load lane extraction.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  input  size_e       rd_size,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rd_lane
);
  logic [31:0] shifted_s;

  // Store side: enables follow the byte offset, data is replicated across lanes
  always_comb begin
    be    = 4'b1111;
    wdata = wr_data;
    case (wr_size)
      SIZE_B: begin
        be    = 4'b0001 << wr_off;
        wdata = {4{wr_data[7:0]}};
      end
      SIZE_H: begin
        be    = 4'b0011 << wr_off;
        wdata = {2{wr_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wr_data;
      end
    endcase
  end

  // Load side: move the addressed lane to bit 0 and zero the rest
  always_comb begin
    shifted_s = rd_word >> {rd_off, 3'b000};
    case (rd_size)
      SIZE_B:  rd_lane = {24'd0, shifted_s[7:0]};
      SIZE_H:  rd_lane = {16'd0, shifted_s[15:0]};
      default: rd_lane = shifted_s;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/ACCESS/RESP sequencer with bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  size_e            size_r;
  logic [1:0]       off_r;
  logic             is_store_r;
  logic             done_r, misaligned_r, bus_error_r;
  logic [31:0]      read_data_r;
  logic             mem_req_r, mem_we_r;
  logic [31:0]      mem_addr_r, mem_wdata_r;
  logic [3:0]       mem_be_r;

  logic             is_load_s, is_store_s, is_mem_s, misaligned_s, stall_s;
  size_e            size_s;
  logic [3:0]       lane_be_s;
  logic [31:0]      lane_wdata_s, lane_rdata_s;

  // Decode the instruction presented by the execute stage
  always_comb begin
    is_load_s    = (bus.opcode == OPC_LOAD);
    is_store_s   = (bus.opcode == OPC_STORE);
    is_mem_s     = is_load_s | is_store_s;
    size_s       = decode_size(is_store_s, bus.funct3);
    misaligned_s = is_misaligned(size_s, bus.addr[1:0]);
  end

  lsu_lane_align u_lane (
    .wr_size (size_s),
    .wr_off  (bus.addr[1:0]),
    .wr_data (bus.store_data),
    .rd_size (size_r),
    .rd_off  (off_r),
    .rd_word (bus.mem_rdata),
    .be      (lane_be_s),
    .wdata   (lane_wdata_s),
    .rd_lane (lane_rdata_s)
  );

  // Hold the pipeline while a memory op is accepted and while it is on the bus
  always_comb begin
    if (state_r == ST_ACCESS) begin
      stall_s = 1'b1;
    end else if (state_r == ST_IDLE) begin
      stall_s = bus.start & is_mem_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Sequencer, registered bus drive, timeout counter and completion status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      size_r       <= SIZE_B;
      off_r        <= 2'b00;
      is_store_r   <= 1'b0;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
      bus_error_r  <= 1'b0;
      read_data_r  <= 32'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_be_r     <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && is_mem_s) begin
            size_r     <= size_s;
            off_r      <= bus.addr[1:0];
            is_store_r <= is_store_s;
            cnt_r      <= '0;
            if (misaligned_s) begin
              // Rejected without touching the bus
              state_r      <= ST_RESP;
              done_r       <= 1'b1;
              misaligned_r <= 1'b1;
              read_data_r  <= 32'd0;
            end else begin
              state_r     <= ST_ACCESS;
              mem_req_r   <= 1'b1;
              mem_we_r    <= is_store_s;
              mem_addr_r  <= {bus.addr[31:2], 2'b00};
              mem_wdata_r <= is_store_s ? lane_wdata_s : 32'd0;
              mem_be_r    <= is_store_s ? lane_be_s : 4'b1111;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the final counted cycle still completes normally
          if (bus.mem_ack) begin
            state_r     <= ST_RESP;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            done_r      <= 1'b1;
            read_data_r <= is_store_r ? 32'd0 : lane_rdata_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= ST_RESP;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            done_r      <= 1'b1;
            bus_error_r <= 1'b1;
            read_data_r <= 32'd0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          done_r       <= 1'b0;
          misaligned_r <= 1'b0;
          bus_error_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall      = stall_s;
  assign bus.done       = done_r;
  assign bus.misaligned = misaligned_r;
  assign bus.bus_error  = bus_error_r;
  assign bus.read_data  = read_data_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_be     = mem_be_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random ops
// compared against a byte-count/arithmetic reference model.
module tb_load_store_unit;
  localparam int TO = 4;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if lsu_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lsu_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bytes touched by an access
  function automatic int nbytes(input logic is_st, input logic [2:0] f3);
    if (is_st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  // Present one instruction, act as memory (ack after wait_n idle ACCESS cycles,
  // never if wait_n >= TO), and check every cycle against the model.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int wait_n);
    logic        is_ld, is_st, is_mem, mis, timeout, ack;
    int          n, off, be_i, lat, exp_lat;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    longint      mask, sh;
    is_ld   = (opc == LOAD);
    is_st   = (opc == STORE);
    is_mem  = is_ld | is_st;
    n       = nbytes(is_st, f3);
    off     = int'(a[1:0]);
    mis     = is_mem && ((off % n) != 0);
    timeout = (wait_n >= TO);
    be_i    = ((1 << n) - 1) << off;
    e_be    = is_st ? be_i[3:0] : 4'hF;
    e_wd    = (n == 1) ? {24'd0, sd[7:0]} * 32'h01010101 :
              (n == 2) ? {16'd0, sd[15:0]} * 32'h00010001 : sd;
    mask    = (64'd1 << (8 * n)) - 64'd1;
    sh      = (longint'(rd) >> (8 * off)) & mask;
    e_rd    = sh[31:0];
    exp_lat = timeout ? TO + 1 : wait_n + 2;

    lsu_bus.start = 1'b1; lsu_bus.opcode = opc; lsu_bus.funct3 = f3;
    lsu_bus.addr = a; lsu_bus.store_data = sd; lsu_bus.mem_rdata = rd;
    lsu_bus.mem_ack = 1'b0;
    #1;
    chk({tag, " stall@start"}, 32'(lsu_bus.stall), 32'(is_mem));
    step();
    lat = 1;
    if (!is_mem) begin
      lsu_bus.start = 1'b0;
      #1;
      chk({tag, " nonmem req"}, 32'(lsu_bus.mem_req), 32'd0);
      chk({tag, " nonmem done"}, 32'(lsu_bus.done), 32'd0);
    end else if (mis) begin
      lsu_bus.start = 1'b0;
      #1;
      chk({tag, " mis req"}, 32'(lsu_bus.mem_req), 32'd0);
      chk({tag, " mis done"}, 32'(lsu_bus.done), 32'd1);
      chk({tag, " mis flag"}, 32'(lsu_bus.misaligned), 32'd1);
      chk({tag, " mis berr"}, 32'(lsu_bus.bus_error), 32'd0);
      chk({tag, " mis rdata"}, lsu_bus.read_data, 32'd0);
      chk({tag, " mis stall"}, 32'(lsu_bus.stall), 32'd0);
      step();
      chk({tag, " mis done end"}, 32'(lsu_bus.done), 32'd0);
    end else begin
      for (int c = 1; c <= TO; c++) begin
        ack = ((c - 1) == wait_n);
        lsu_bus.mem_ack = ack;
        #1;
        chk({tag, " req"}, 32'(lsu_bus.mem_req), 32'd1);
        chk({tag, " we"}, 32'(lsu_bus.mem_we), 32'(is_st));
        chk({tag, " maddr"}, lsu_bus.mem_addr, {a[31:2], 2'b00});
        chk({tag, " be"}, 32'(lsu_bus.mem_be), 32'(e_be));
        if (is_st) chk({tag, " wdata"}, lsu_bus.mem_wdata, e_wd);
        chk({tag, " stall acc"}, 32'(lsu_bus.stall), 32'd1);
        chk({tag, " done acc"}, 32'(lsu_bus.done), 32'd0);
        step();
        lat++;
        if (ack) break;
      end
      lsu_bus.mem_ack = 1'b0;
      lsu_bus.start   = 1'b0;
      #1;
      chk({tag, " done"}, 32'(lsu_bus.done), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " berr"}, 32'(lsu_bus.bus_error), 32'(timeout));
      chk({tag, " misflag"}, 32'(lsu_bus.misaligned), 32'd0);
      chk({tag, " req resp"}, 32'(lsu_bus.mem_req), 32'd0);
      chk({tag, " stall resp"}, 32'(lsu_bus.stall), 32'd0);
      if (is_ld) chk({tag, " rdata"}, lsu_bus.read_data, timeout ? 32'd0 : e_rd);
      step();
      chk({tag, " done end"}, 32'(lsu_bus.done), 32'd0);
      if (is_ld) chk({tag, " rdata hold"}, lsu_bus.read_data, timeout ? 32'd0 : e_rd);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    int          kind;

    rst_n = 1'b0;
    lsu_bus.start = 1'b0; lsu_bus.opcode = 7'd0; lsu_bus.funct3 = 3'd0;
    lsu_bus.addr = 32'd0; lsu_bus.store_data = 32'd0;
    lsu_bus.mem_ack = 1'b0; lsu_bus.mem_rdata = 32'd0;
    step();
    step();
    chk("rst done", 32'(lsu_bus.done), 32'd0);
    chk("rst stall", 32'(lsu_bus.stall), 32'd0);
    chk("rst req", 32'(lsu_bus.mem_req), 32'd0);
    chk("rst we", 32'(lsu_bus.mem_we), 32'd0);
    chk("rst maddr", lsu_bus.mem_addr, 32'd0);
    chk("rst wdata", lsu_bus.mem_wdata, 32'd0);
    chk("rst be", 32'(lsu_bus.mem_be), 32'd0);
    chk("rst rdata", lsu_bus.read_data, 32'd0);
    chk("rst mis", 32'(lsu_bus.misaligned), 32'd0);
    chk("rst berr", 32'(lsu_bus.bus_error), 32'd0);
    rst_n = 1'b1;

    // Stray ack while idle is ignored
    lsu_bus.mem_ack = 1'b1;
    step();
    lsu_bus.mem_ack = 1'b0;
    #1;
    chk("idle ack done", 32'(lsu_bus.done), 32'd0);
    chk("idle ack req", 32'(lsu_bus.mem_req), 32'd0);

    run_op("sw100", STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0);
    run_op("sb203", STORE, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'd0, 0);
    run_op("sh302", STORE, 3'b001, 32'h0000_0302, 32'h1234_5678, 32'd0, 1);
    run_op("lh302", LOAD,  3'b001, 32'h0000_0302, 32'd0, 32'h8001_1234, 3);
    run_op("lbu301", LOAD, 3'b100, 32'h0000_0301, 32'd0, 32'hCAFE_F00D, 2);
    run_op("lw101", LOAD,  3'b010, 32'h0000_0101, 32'd0, 32'd0, 0);
    run_op("sh301", STORE, 3'b001, 32'h0000_0301, 32'h1111_2222, 32'd0, 0);
    run_op("lb203", LOAD,  3'b000, 32'h0000_0203, 32'd0, 32'h9988_7766, 0);
    run_op("lwto", LOAD,   3'b010, 32'h0000_0080, 32'd0, 32'h5555_AAAA, 99);
    run_op("lwlast", LOAD, 3'b010, 32'h0000_0080, 32'd0, 32'h5555_AAAA, TO - 1);
    run_op("lw011", LOAD,  3'b011, 32'h0000_0044, 32'd0, 32'h0BAD_CAFE, 0);
    run_op("st111", STORE, 3'b111, 32'h0000_0048, 32'h0102_0304, 32'd0, 0);
    run_op("alu", ALU,     3'b000, 32'h0000_0001, 32'd0, 32'd0, 0);

    // Reset during the second ACCESS cycle abandons the transfer
    lsu_bus.start = 1'b1; lsu_bus.opcode = LOAD; lsu_bus.funct3 = 3'b010;
    lsu_bus.addr = 32'h0000_0040; lsu_bus.mem_ack = 1'b0;
    step();
    chk("rstacc req1", 32'(lsu_bus.mem_req), 32'd1);
    step();
    chk("rstacc req2", 32'(lsu_bus.mem_req), 32'd1);
    rst_n = 1'b0;
    lsu_bus.start = 1'b0;
    step();
    chk("rstacc req", 32'(lsu_bus.mem_req), 32'd0);
    chk("rstacc done", 32'(lsu_bus.done), 32'd0);
    chk("rstacc stall", 32'(lsu_bus.stall), 32'd0);
    chk("rstacc be", 32'(lsu_bus.mem_be), 32'd0);
    rst_n = 1'b1;
    lsu_bus.mem_ack = 1'b1;
    step();
    lsu_bus.mem_ack = 1'b0;
    #1;
    chk("rstacc late ack done", 32'(lsu_bus.done), 32'd0);
    chk("rstacc late ack req", 32'(lsu_bus.mem_req), 32'd0);
    step();
    chk("rstacc after done", 32'(lsu_bus.done), 32'd0);

    // Random mix of loads, stores and non-memory instructions
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      opc  = (kind < 2) ? LOAD : (kind < 4) ? STORE : ALU;
      r    = $urandom;
      run_op("rnd", opc, r[2:0], $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles ACCESS waits for mem_ack.
REQ-002 The block SHALL have the following ports; clock and reset first.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  execute stage presents an instruction; held high while stall=1.
- opcode  in  7  instruction opcode.
- funct3  in  3  access size and sign.
- addr  in  32  effective byte address (ALU result).
- store_data  in  32  rs2 value.
- stall  out  1  freezes the PC and register write.
- done  out  1  one-cycle completion pulse.
- read_data  out  32  load lane right-justified to bit 0, upper bits zero; the register-write side extends it.
- misaligned  out  1  valid with done.
- bus_error  out  1  valid with done.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read word.

Function
REQ-003 The block SHALL treat opcode 0000011 as a load and 0100011 as a store; all other opcodes SHALL produce stall=0, no state change and no bus activity.
REQ-004 The state machine SHALL have states IDLE, ACCESS and RESP. Transitions:
- IDLE to ACCESS on start with an aligned memory op.
- IDLE to RESP on start with a misaligned op.
- ACCESS to RESP on mem_ack or on timeout.
- RESP to IDLE unconditionally.
REQ-005 stall SHALL be 1 in IDLE when start is high with a memory op, 1 throughout ACCESS, and 0 in RESP.
REQ-006 Alignment SHALL be defined as follows:
- LH, LHU and SH with addr[0]=1 are misaligned.
- LW and SW with addr[1:0]!=0 are misaligned.
- Bytes are never misaligned.
REQ-007 A misaligned op SHALL cause no bus activity; the RESP cycle SHALL have done=1, misaligned=1 and read_data=0.
REQ-008 The op fields SHALL be registered on IDLE exit, and mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be driven from registers, stable for the whole of ACCESS.
REQ-009 mem_be SHALL be:
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<addr[1:0].
- SW: 4'b1111.
- Loads: 4'b1111.
REQ-010 mem_wdata SHALL be {4{byte}} for SB, {2{half}} for SH and store_data for SW.
REQ-011 Stores with a funct3 other than 000 or 001 SHALL be treated as SW; loads with funct3 011, 110 or 111 SHALL be treated as LW.
REQ-012 On mem_ack in ACCESS, the block SHALL capture mem_rdata>>(8*addr[1:0]), masked to 8 bits (LB/LBU), 16 bits (LH/LHU) or 32 bits (LW); read_data SHALL hold this value until the next op completes.
REQ-013 Latency SHALL be as follows:
- start sampled in IDLE at edge 0.
- mem_req is high from cycle 1.
- With mem_ack high in cycle k, done=1 in cycle k+1.
- Minimum start-to-done is 2 cycles.
REQ-014 An ACCESS cycle counter SHALL run; when it reaches TIMEOUT_CYCLES without mem_ack, the block SHALL go to RESP with bus_error=1 and read_data=0.
REQ-015 mem_ack arriving in the same cycle as the timeout SHALL win: the op completes normally with bus_error=0.
REQ-016 mem_ack outside ACCESS SHALL be ignored.
REQ-017 done, misaligned and bus_error SHALL be high only in RESP; start is ignored during RESP.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL return to IDLE and clear the following to 0: stall, done, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_wdata, mem_be, read_data and the timeout counter.
REQ-019 A reset asserted during ACCESS SHALL abandon the transfer with no done pulse; mem_req SHALL be low from the cycle after the reset edge.

Structure
REQ-020 Package lsu_pkg SHALL hold:
- The LOAD and STORE opcode constants.
- The funct3 size codes.
- The IDLE/ACCESS/RESP state encoding.
- The default TIMEOUT_CYCLES.
REQ-021 Byte-lane steering (mem_be, mem_wdata, read-lane extraction) SHALL live in one combinational sub-module, lsu_lane_align.

Verification
REQ-022 SW, addr=0x100, store_data=0xDEADBEEF, ack on first ACCESS cycle: mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, done 2 cycles after start.
REQ-023 SB, addr=0x203, store_data=0x000000A5: mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-024 LH, addr=0x302, mem_rdata=0x8001_1234, ack after 3 wait cycles: read_data=0x00008001, done 5 cycles after start, stall high throughout until RESP.
REQ-025 LW, addr=0x101: no mem_req; next cycle done=1, misaligned=1, read_data=0.
REQ-026 LW with TIMEOUT_CYCLES=4 and no ack: done=1, bus_error=1; repeat with ack in the 4th ACCESS cycle: bus_error=0.
REQ-027 Reset asserted in the 2nd ACCESS cycle of an LW: mem_req=0 and state IDLE after the edge, no done pulse, a later ack ignored.
